mem_access_guard: RTL

MEM_ACCESS_GUARD -- requirements
Module: mem_access_guard

---
 rtl/mem_access_guard.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_access_guard.sv
// mem_access_guard: screens load/store requests for alignment and region legality,
// latches the first resulting exception until acknowledged, and counts exceptions.
`default_nettype none

module mem_access_guard #(
    parameter int                       ADDR_W       = 32,
    parameter int                       NREG         = 3,
    parameter logic [NREG*ADDR_W-1:0]   REG_BASE     = {32'h7f10, 32'h7f00, 32'h0000},
    parameter logic [NREG*ADDR_W-1:0]   REG_LIMIT    = {32'h7f1b, 32'h7f0b, 32'h2fff},
    parameter logic [NREG-1:0]          REG_WORDONLY = 3'b110,
    parameter int                       CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_exc,
    input  logic [4:0]        in_exc_code,
    output logic              acc_ok,
    output logic              exc_valid,
    output logic [4:0]        exc_code,
    output logic [ADDR_W-1:0] bad_vaddr,
    input  logic              exc_ack,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [4:0] C_CODE_ADEL = 5'd4;
    localparam logic [4:0] C_CODE_ADES = 5'd5;
    localparam logic [4:0] C_CODE_OV   = 5'd12;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                acc_ok_q, acc_ok_d;
    logic [4:0]          exc_code_q, exc_code_d;
    logic [ADDR_W-1:0]   bad_vaddr_q, bad_vaddr_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    logic                w_hit;
    logic                w_wordonly;
    logic                w_align_err;
    logic                w_range_err;
    logic                w_addr_err;
    logic                w_any_exc;
    logic                w_accept;
    logic [4:0]          w_code;

    // Scan from the top region down so the lowest-index match wins.
    always_comb begin
        w_hit      = 1'b0;
        w_wordonly = 1'b0;
        for (int k = NREG - 1; k >= 0; k--) begin
            if ((in_addr >= REG_BASE[k*ADDR_W +: ADDR_W]) &&
                (in_addr <= REG_LIMIT[k*ADDR_W +: ADDR_W])) begin
                w_hit      = 1'b1;
                w_wordonly = REG_WORDONLY[k];
            end
        end
    end

    always_comb begin
        case (in_size)
            2'b00:   w_align_err = 1'b0;
            2'b01:   w_align_err = in_addr[0];
            2'b10:   w_align_err = (in_addr[1:0] != 2'b00);
            default: w_align_err = 1'b1;
        endcase
    end

    assign w_range_err = !w_hit || (w_wordonly && (in_size != 2'b10));
    // An upstream overflow is reported as an address error on this access.
    assign w_addr_err  = w_align_err || w_range_err || (in_exc && (in_exc_code == C_CODE_OV));
    assign w_any_exc   = w_addr_err || in_exc;
    assign w_code      = w_addr_err ? (in_store ? C_CODE_ADES : C_CODE_ADEL) : in_exc_code;
    assign w_accept    = in_valid && (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        acc_ok_d    = 1'b0;
        exc_code_d  = exc_code_q;
        bad_vaddr_d = bad_vaddr_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (w_any_exc) begin
                        state_d     = PEND;
                        exc_code_d  = w_code;
                        bad_vaddr_d = in_addr;
                        if (err_cnt_q != {CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end else begin
                        acc_ok_d = 1'b1;
                    end
                end
            end
            PEND: begin
                if (exc_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_ok_q    <= 1'b0;
            exc_code_q  <= 5'd0;
            bad_vaddr_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_ok_q    <= acc_ok_d;
            exc_code_q  <= exc_code_d;
            bad_vaddr_q <= bad_vaddr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign acc_ok    = acc_ok_q;
    assign exc_valid = (state_q == PEND);
    assign exc_code  = exc_code_q;
    assign bad_vaddr = bad_vaddr_q;
    assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire
